// File: rtl/half_mult_pipe.sv
// Elastic FIFO + two-register pipeline around a combinational binary16 multiplier.
// Results carry exception flags; a sticky copy accumulates over consumed results.

module float_mult_16bit (
  input  logic [15:0] float1,
  input  logic [15:0] float2,
  output logic [15:0] product
);
  logic              sign;
  logic [4:0]        exp_a;
  logic [4:0]        exp_b;
  logic [9:0]        man_a;
  logic [9:0]        man_b;
  logic              a_zero;
  logic              b_zero;
  logic              a_inf;
  logic              b_inf;
  logic              a_nan;
  logic              b_nan;
  logic [4:0]        eff_a;
  logic [4:0]        eff_b;
  logic [10:0]       sig_a;
  logic [10:0]       sig_b;
  logic [21:0]       sig_prod;
  logic [4:0]        lead;
  logic [21:0]       norm;
  logic signed [7:0] exp_biased;
  logic [5:0]        shift;
  logic [33:0]       wide;
  logic [32:0]       shifted;
  logic              lost;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [4:0]        exp_field;
  logic [14:0]       rounded;

  assign sign   = float1[15] ^ float2[15];
  assign exp_a  = float1[14:10];
  assign exp_b  = float2[14:10];
  assign man_a  = float1[9:0];
  assign man_b  = float2[9:0];
  assign a_zero = (exp_a == 5'd0) && (man_a == 10'd0);
  assign b_zero = (exp_b == 5'd0) && (man_b == 10'd0);
  assign a_inf  = (exp_a == 5'h1F) && (man_a == 10'd0);
  assign b_inf  = (exp_b == 5'h1F) && (man_b == 10'd0);
  assign a_nan  = (exp_a == 5'h1F) && (man_a != 10'd0);
  assign b_nan  = (exp_b == 5'h1F) && (man_b != 10'd0);

  // Subnormals use exponent 1 with no hidden bit.
  assign eff_a    = (exp_a == 5'd0) ? 5'd1 : exp_a;
  assign eff_b    = (exp_b == 5'd0) ? 5'd1 : exp_b;
  assign sig_a    = {exp_a != 5'd0, man_a};
  assign sig_b    = {exp_b != 5'd0, man_b};
  assign sig_prod = sig_a * sig_b;

  always_comb begin
    lead = 5'd0;
    for (int i = 0; i < 22; i++) begin
      if (sig_prod[i]) lead = 5'(i);
    end
  end

  assign norm       = sig_prod << (5'd21 - lead);
  assign exp_biased = $signed({3'b000, lead}) + $signed({3'b000, eff_a})
                    + $signed({3'b000, eff_b}) - 8'sd35;
  assign shift      = (exp_biased > 8'sd0) ? 6'd0 : 6'(8'sd1 - exp_biased);
  assign wide       = {norm, 12'd0};
  assign shifted    = 33'(wide >> shift);

  always_comb begin
    lost = 1'b0;
    for (int i = 0; i < 34; i++) begin
      if (6'(i) < shift) lost = lost | wide[i];
    end
  end

  assign guard     = shifted[22];
  assign sticky    = (shifted[21:0] != 22'd0) || lost;
  assign round_up  = guard && (sticky || shifted[23]);
  assign exp_field = (exp_biased > 8'sd0) ? exp_biased[4:0] : 5'd0;
  // A rounding carry out of the mantissa bumps the exponent field naturally.
  assign rounded   = {exp_field, shifted[32:23]} + {14'd0, round_up};

  always_comb begin
    product = {sign, rounded};
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      product = 16'hFFFF;
    end else if (a_inf || b_inf) begin
      product = {sign, 5'h1F, 10'd0};
    end else if (a_zero || b_zero) begin
      product = {sign, 15'd0};
    end else if (exp_biased > 8'sd30) begin
      product = {sign, 5'h1F, 10'd0};
    end
  end
endmodule

module half_mult_pipe #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              CLK,
  input  logic                              nRST,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [15:0]                       float1,
  input  logic [15:0]                       float2,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [15:0]                       product,
  output logic [3:0]                        out_flags,
  output logic [3:0]                        sticky_flags,
  input  logic                              clr_sticky,
  input  logic                              flush,
  output logic [$clog2(FIFO_DEPTH+3)-1:0]   occupancy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(FIFO_DEPTH + 3);

  logic [31:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic [AW:0] fifo_count;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic [31:0] head;
  logic        head_nv;

  logic [15:0] s1_a_reg;
  logic [15:0] s1_b_reg;
  logic        s1_nv_reg;
  logic        s1_valid_reg;
  logic        s1_load;

  logic [15:0] mult_p;
  logic [3:0]  flags_next;
  logic [15:0] product_reg;
  logic [3:0]  flags_reg;
  logic        s2_valid_reg;
  logic        s2_load;
  logic [3:0]  sticky_reg;
  logic        out_fire;

  function automatic logic is_zero(input logic [15:0] f);
    return f[14:0] == 15'd0;
  endfunction

  function automatic logic is_inf(input logic [15:0] f);
    return (f[14:10] == 5'h1F) && (f[9:0] == 10'd0);
  endfunction

  function automatic logic is_snan(input logic [15:0] f);
    return (f[14:10] == 5'h1F) && !f[9] && (f[9:0] != 10'd0);
  endfunction

  assign full       = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty      = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_count = wr_ptr_reg - rd_ptr_reg;

  // Backward ready chain runs from the output register towards the FIFO.
  assign s2_load  = !s2_valid_reg || out_ready;
  assign s1_load  = !s1_valid_reg || s2_load;
  assign pop      = !empty && s1_load;
  assign in_ready = !full && !flush;
  assign push     = in_valid && in_ready;
  assign out_fire = s2_valid_reg && out_ready;

  assign head    = fifo_mem[rd_ptr_reg[AW-1:0]];
  assign head_nv = (is_zero(head[31:16]) && is_inf(head[15:0])) ||
                   (is_inf(head[31:16]) && is_zero(head[15:0])) ||
                   is_snan(head[31:16]) || is_snan(head[15:0]);

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr_reg[AW-1:0]] <= {float1, float2};
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      s1_a_reg     <= 16'd0;
      s1_b_reg     <= 16'd0;
      s1_nv_reg    <= 1'b0;
      s1_valid_reg <= 1'b0;
    end else if (flush) begin
      s1_valid_reg <= 1'b0;
    end else if (s1_load) begin
      s1_valid_reg <= pop;
      if (pop) begin
        s1_a_reg  <= head[31:16];
        s1_b_reg  <= head[15:0];
        s1_nv_reg <= head_nv;
      end
    end
  end

  float_mult_16bit u_mult (
    .float1  (s1_a_reg),
    .float2  (s1_b_reg),
    .product (mult_p)
  );

  assign flags_next = {
    s1_nv_reg || ((mult_p[14:10] == 5'h1F) && (mult_p[9:0] != 10'd0)),
    (mult_p[14:10] == 5'h1F) && (mult_p[9:0] == 10'd0),
    mult_p[14:0] == 15'd0,
    (mult_p[14:10] == 5'd0) && (mult_p[9:0] != 10'd0)
  };

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      product_reg  <= 16'd0;
      flags_reg    <= 4'd0;
      s2_valid_reg <= 1'b0;
    end else if (flush) begin
      s2_valid_reg <= 1'b0;
    end else if (s2_load) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        product_reg <= mult_p;
        flags_reg   <= flags_next;
      end
    end
  end

  // A clear coinciding with a handshake keeps only that handshake's flags.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sticky_reg <= 4'd0;
    end else if (clr_sticky) begin
      sticky_reg <= out_fire ? flags_reg : 4'd0;
    end else if (out_fire) begin
      sticky_reg <= sticky_reg | flags_reg;
    end
  end

  assign out_valid    = s2_valid_reg;
  assign product      = product_reg;
  assign out_flags    = flags_reg;
  assign sticky_flags = sticky_reg;
  assign occupancy    = OW'(fifo_count) + OW'(s1_valid_reg) + OW'(s2_valid_reg);
endmodule

// File: tb/tb_half_mult_pipe.sv
// Scoreboard bench for half_mult_pipe: stimulus pushes expected results,
// a negedge monitor pops and compares on every output handshake.

module tb_half_mult_pipe;
  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] float1 = 16'd0;
  logic [15:0] float2 = 16'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] product;
  logic [3:0]  out_flags;
  logic [3:0]  sticky_flags;
  logic        clr_sticky = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  occupancy;

  int tests_run = 0;
  int tests_failed = 0;
  int hs_count = 0;

  typedef struct packed {logic [15:0] p; logic [3:0] f;} exp_t;
  typedef struct packed {logic [15:0] a; logic [15:0] b; logic [15:0] p; logic [3:0] f;} vec_t;

  exp_t exp_q[$];
  vec_t vecs [10];
  vec_t excs [4];

  half_mult_pipe #(.FIFO_DEPTH(4)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .float1       (float1),
    .float2       (float2),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .out_flags    (out_flags),
    .sticky_flags (sticky_flags),
    .clr_sticky   (clr_sticky),
    .flush        (flush),
    .occupancy    (occupancy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Inputs are stable at the negedge, so out_valid && out_ready here is the next edge's handshake.
  always @(negedge CLK) begin
    exp_t e;
    if (nRST && out_valid && out_ready) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_output: got product 0x%h, expected no output", product);
      end else begin
        e = exp_q.pop_front();
        check("product", product, e.p);
        check("out_flags", out_flags, e.f);
        $display("[TB] result product=%h flags=%b (expected %h/%b)", product, out_flags, e.p, e.f);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send(input vec_t v);
    bit done = 1'b0;
    in_valid = 1'b1;
    float1 = v.a;
    float2 = v.b;
    for (int c = 0; c < 64 && !done; c++) begin
      done = in_ready;
      @(posedge CLK);
      if (done) exp_q.push_back({v.p, v.f});
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_timeout: in_ready stayed 0, expected acceptance");
    end
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) tick(1);
    tick(2);
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic latency_op(input string name, input vec_t v);
    out_ready = 1'b1;
    in_valid = 1'b1;
    float1 = v.a;
    float2 = v.b;
    check({name, "_in_ready"}, in_ready, 1);
    @(posedge CLK);
    exp_q.push_back({v.p, v.f});
    #1;
    in_valid = 1'b0;
    check({name, "_valid_t1"}, out_valid, 0);
    tick(1);
    check({name, "_valid_t2"}, out_valid, 0);
    tick(1);
    check({name, "_valid_t3"}, out_valid, 1);
    check({name, "_product_t3"}, product, v.p);
    tick(1);
    check({name, "_valid_after"}, out_valid, 0);
  endtask

  initial begin
    bit ok;
    int idx;
    int base;
    int occ_max;

    vecs[0] = {16'h3C00, 16'h4000, 16'h4000, 4'b0000};
    vecs[1] = {16'h4000, 16'h4200, 16'h4600, 4'b0000};
    vecs[2] = {16'h4200, 16'h4200, 16'h4880, 4'b0000};
    vecs[3] = {16'h3800, 16'h4600, 16'h4200, 4'b0000};
    vecs[4] = {16'hC000, 16'h4000, 16'hC400, 4'b0000};
    vecs[5] = {16'h3C00, 16'h0001, 16'h0001, 4'b0001};
    vecs[6] = {16'h7BFF, 16'h4000, 16'h7C00, 4'b0100};
    vecs[7] = {16'h0200, 16'h3800, 16'h0100, 4'b0001};
    vecs[8] = {16'h3C01, 16'h3C01, 16'h3C02, 4'b0000};
    vecs[9] = {16'h3BFF, 16'h3BFF, 16'h3BFE, 4'b0000};
    excs[0] = {16'h7C00, 16'h0000, 16'hFFFF, 4'b1000};
    excs[1] = {16'h7C00, 16'h3C00, 16'h7C00, 4'b0100};
    excs[2] = {16'h0000, 16'h4500, 16'h0000, 4'b0010};
    excs[3] = {16'h7D00, 16'h3C00, 16'hFFFF, 4'b1000};

    // Reset state
    tick(2);
    nRST = 1'b1;
    tick(1);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_product", product, 16'h0000);
    check("rst_out_flags", out_flags, 4'd0);
    check("rst_sticky", sticky_flags, 4'd0);
    check("rst_occupancy", occupancy, 3'd0);

    // Single operations with 3-cycle latency
    latency_op("single", vecs[0]);
    send(vecs[1]);
    drain("single2");

    // Exceptions and sticky
    for (int i = 0; i < 4; i++) send(excs[i]);
    drain("exc");
    check("exc_sticky", sticky_flags, 4'b1110);
    clr_sticky = 1'b1;
    tick(1);
    clr_sticky = 1'b0;
    check("exc_sticky_clr", sticky_flags, 4'b0000);

    // Backpressure: 8 pairs, out_ready low for 10 cycles
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = (idx < 8);
      float1 = vecs[idx % 10].a;
      float2 = vecs[idx % 10].b;
      ok = in_ready && in_valid;
      @(posedge CLK);
      if (ok) begin
        exp_q.push_back({vecs[idx].p, vecs[idx].f});
        idx++;
      end
      #1;
    end
    check("bp_accepted", idx, 6);
    check("bp_occupancy", occupancy, 3'd6);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_hold_product", product, vecs[0].p);
    out_ready = 1'b1;
    base = hs_count;
    for (int c = 0; c < 8; c++) begin
      in_valid = (idx < 8);
      float1 = vecs[idx % 10].a;
      float2 = vecs[idx % 10].b;
      ok = in_ready && in_valid;
      @(posedge CLK);
      if (ok) begin
        exp_q.push_back({vecs[idx].p, vecs[idx].f});
        idx++;
      end
      #1;
    end
    in_valid = 1'b0;
    check("bp_outputs_in_8_cycles", hs_count - base, 8);
    check("bp_all_sent", idx, 8);
    drain("bp");

    // FIFO wrap: 20 ops, out_ready toggling
    idx = 0;
    occ_max = 0;
    for (int c = 0; c < 200 && idx < 20; c++) begin
      out_ready = c[0];
      in_valid = 1'b1;
      float1 = vecs[idx % 10].a;
      float2 = vecs[idx % 10].b;
      ok = in_ready;
      @(posedge CLK);
      if (ok) begin
        exp_q.push_back({vecs[idx % 10].p, vecs[idx % 10].f});
        idx++;
      end
      #1;
      if (int'(occupancy) > occ_max) occ_max = int'(occupancy);
    end
    in_valid = 1'b0;
    check("wrap_sent", idx, 20);
    check("wrap_occ_over_6", occ_max > 6, 0);
    drain("wrap");

    // Flush with 5 in flight
    clr_sticky = 1'b1;
    tick(1);
    clr_sticky = 1'b0;
    out_ready = 1'b0;
    send(excs[1]);
    for (int i = 0; i < 4; i++) send(vecs[i]);
    tick(2);
    check("flush_pre_occupancy", occupancy, 3'd5);
    flush = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    float1 = vecs[4].a;
    float2 = vecs[4].b;
    #1;
    check("flush_in_ready", in_ready, 0);
    @(posedge CLK);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_occupancy", occupancy, 3'd0);
    check("flush_out_valid", out_valid, 0);
    check("flush_sticky", sticky_flags, 4'b0100);
    check("flush_left_in_queue", exp_q.size(), 4);
    exp_q.delete();
    tick(3);
    check("flush_idle_valid", out_valid, 0);
    check("flush_idle_occupancy", occupancy, 3'd0);

    // Async reset mid-stream
    out_ready = 1'b1;
    send(excs[1]);
    send(vecs[1]);
    tick(3);
    out_ready = 1'b0;
    send(vecs[2]);
    send(vecs[3]);
    send(vecs[4]);
    tick(3);
    check("pre_rst_sticky", sticky_flags, 4'b0100);
    check("pre_rst_product", product, vecs[2].p);
    @(posedge CLK);
    #3;
    nRST = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_product", product, 16'h0000);
    check("arst_out_flags", out_flags, 4'd0);
    check("arst_sticky", sticky_flags, 4'd0);
    check("arst_occupancy", occupancy, 3'd0);
    check("arst_in_ready", in_ready, 1);
    exp_q.delete();
    #2;
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    latency_op("post_rst", vecs[1]);
    drain("final");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/half_mult_pipe.md
# half_mult_pipe

Pipelined, flow-controlled wrapper that feeds the combinational half-precision multiplier `float_mult_16bit`. It buffers incoming operand pairs in a small FIFO and registers operands and result around the multiplier. It classifies each result into exception flags, keeps sticky status, and presents products on a valid/ready output port. It sits between the FPU issue logic (upstream) and result writeback (downstream).

## Interface
- `FIFO_DEPTH`, 4: input FIFO entries; power of two, ≥2.
- `CLK` in 1: clock, rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: FIFO can accept this cycle.
- `float1` in 16: operand A, IEEE binary16.
- `float2` in 16: operand B, IEEE binary16.
- `out_valid` out 1: product valid.
- `out_ready` in 1: consumer accepts product.
- `product` out 16: registered multiplier result.
- `out_flags` out 4: {nv, inf, zero, sub} for the current `product`.
- `sticky_flags` out 4: OR of `out_flags` over all accepted outputs.
- `clr_sticky` in 1: synchronous clear of `sticky_flags`.
- `flush` in 1: synchronous discard of all in-flight work.
- `occupancy` out $clog2(FIFO_DEPTH+3): entries held in FIFO + S1 + S2.

## Operation
- Input handshake on `in_valid && in_ready`. `in_ready = !full && !flush`.
- FIFO: circular buffer with read and write pointers one bit wider than the index. Full when the MSBs differ and the rest are equal. Empty when the pointers are equal. Wrap-around is natural modulo 2·FIFO_DEPTH. Simultaneous push and pop while full is not allowed, because `in_ready` is already low. Simultaneous push and pop at any other fill level keeps the count unchanged.
- S1 register: holds {A, B, s1_valid} and the precomputed input class `nv_in`. `nv_in = (zero×inf) || SNaN on either input`. SNaN means exp=1F, mant[9]=0, mant≠0.
- The `float_mult_16bit` instance takes the S1 operands combinationally.
- S2 register: holds {product, out_flags, s2_valid}. `out_valid = s2_valid`.
- Flags are computed from the multiplier output `p`:
  - nv = `nv_in || (p[14:10]==1F && p[9:0]!=0)`
  - inf = `p[14:10]==1F && p[9:0]==0`
  - zero = `p[14:0]==0`
  - sub = `p[14:10]==0 && p[9:0]!=0`
- Advance rule, one elastic pipeline:
  - S2 loads when `!s2_valid || out_ready`.
  - S1 loads when `!s1_valid || S2 loads`.
  - The FIFO pops when it is non-empty and S1 loads.
  - Full throughput is 1 result/cycle under continuous `out_ready`.
- Backpressure: while `out_valid && !out_ready`, `product` and `out_flags` hold stable. S1 and the FIFO fill; no data is dropped or duplicated.
- Sticky: on `out_valid && out_ready`, `sticky_flags |= out_flags`. `clr_sticky` has priority. If `clr_sticky` occurs in the same cycle as a handshake, the result is the flags of that handshake only.
- Flush: next state clears the FIFO pointers, `s1_valid` and `s2_valid`. Input is not accepted that cycle. A handshake occurring in the flush cycle still counts toward sticky. `sticky_flags` is otherwise untouched by flush.
- `occupancy` = FIFO count + `s1_valid` + `s2_valid`. It updates every edge.

## Timing
- Reset values (async, on `nRST` low):
  - pointers = 0
  - `s1_valid` = `s2_valid` = 0
  - `product` = 0x0000
  - `out_flags` = 0
  - `sticky_flags` = 0
  - `occupancy` = 0
  - `in_ready` = 1 after the `nRST` deassert edge
- Latency on an empty pipe:
  - Operand accepted at edge t.
  - Written to the FIFO at t, popped into S1 at t+1, registered into S2 at t+2.
  - `out_valid` is high in the cycle after edge t+2: 3 cycles.
- No combinational path from `out_ready` to `in_ready`; `in_ready` depends on registered state and `flush` only.
- Reset asserted mid-operation discards everything immediately. All outputs return to reset values asynchronously.

## Test plan
- Single op: 0x3C00 × 0x4000 → `product` 0x4000 exactly 3 cycles after accept, flags 0000. Then 0x4000 × 0x4200 → 0x4600.
- Exceptions, with `sticky_flags` checked after all four:
  - 0x7C00 × 0x0000 → 0xFFFF, nv=1.
  - 0x7C00 × 0x3C00 → 0x7C00, inf=1.
  - 0x0000 × 0x4500 → 0x0000, zero=1.
  - `sticky_flags` = 1110.
  - `clr_sticky` → 0000.
- Backpressure: stream 8 distinct pairs with `out_ready` low for 10 cycles.
  - `in_ready` drops once `occupancy` = FIFO_DEPTH+2 = 6.
  - Raising `out_ready` yields all 8 products in order, one per cycle, none lost.
- FIFO wrap: 20 back-to-back ops with `out_ready` toggling at 50%. Output sequence matches a reference model; `occupancy` never exceeds 6.
- Flush with 5 items in flight, `out_ready` high in the flush cycle:
  - That cycle's product is consumed and counted in sticky.
  - Next cycle `occupancy` = 0, `out_valid` = 0.
  - An `in_valid` presented during flush is not accepted.
- Async reset asserted mid-stream, away from a clock edge: all outputs read reset values before the next edge. First op after release completes with 3-cycle latency.
